// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between MLP layers: captures a full output
// vector and replays it one word per cycle, with a one-deep pending slot.
module layer_serializer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  output logic [dataWidth-1:0]    x_out,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    valid_mismatch
);

  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]              state, state_n;
  logic [NN*dataWidth-1:0] active, active_n;
  logic [NN*dataWidth-1:0] pending, pending_n;
  logic                    pend_v, pend_n;
  logic [IW-1:0]           idx, idx_n;
  logic                    ovr_n, mm_n;
  logic                    capture;
  logic [dataWidth-1:0]    word_n;

  assign capture = &in_valid;
  assign busy    = (state == SEND);

  always_comb begin
    state_n   = state;
    active_n  = active;
    pending_n = pending;
    pend_n    = pend_v;
    idx_n     = idx;
    ovr_n     = overrun;
    mm_n      = valid_mismatch | (|in_valid & ~capture);
    case (state)
      IDLE: begin
        if (capture) begin
          active_n = in_data;
          idx_n    = '0;
          state_n  = SEND;
        end
      end
      default: begin
        if (idx != LAST) begin
          idx_n = idx + 1'b1;
          if (capture) begin
            if (!pend_v) begin
              pending_n = in_data;
              pend_n    = 1'b1;
            end else begin
              ovr_n = 1'b1;
            end
          end
        end else if (pend_v) begin
          // Queued vector follows with no bubble; a coincident capture refills the slot.
          active_n = pending;
          idx_n    = '0;
          if (capture) pending_n = in_data;
          else pend_n = 1'b0;
        end else if (capture) begin
          active_n = in_data;
          idx_n    = '0;
        end else begin
          idx_n   = '0;
          state_n = IDLE;
        end
      end
    endcase
    word_n = active_n[idx_n*dataWidth +: dataWidth];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      active         <= '0;
      pending        <= '0;
      pend_v         <= 1'b0;
      idx            <= '0;
      overrun        <= 1'b0;
      valid_mismatch <= 1'b0;
      x_valid        <= 1'b0;
      x_out          <= '0;
    end else begin
      state          <= state_n;
      active         <= active_n;
      pending        <= pending_n;
      pend_v         <= pend_n;
      idx            <= idx_n;
      overrun        <= ovr_n;
      valid_mismatch <= mm_n;
      x_valid        <= (state_n == SEND);
      x_out          <= (state_n == SEND) ? word_n : '0;
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Directed scenario table for layer_serializer: each row lists captures,
// the bursts they must produce, and the windows where the flags are set.
module tb_layer_serializer;
  localparam int NN = 10;
  localparam int DW = 16;
  localparam int NC = 40;
  localparam int NS = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NN-1:0]    in_valid = '0;
  logic [NN*DW-1:0] in_data = '0;
  logic [DW-1:0]    x_out;
  logic             x_valid, busy, overrun, valid_mismatch;

  int total = 0;
  int passed = 0;

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .x_out(x_out), .x_valid(x_valid), .busy(busy),
    .overrun(overrun), .valid_mismatch(valid_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            cap [3];
    logic [NN-1:0] cv  [3];
    logic [DW-1:0] cb  [3];
    int            bs  [3];
    int            bl  [3];
    logic [DW-1:0] bb  [3];
    int            ovs, ove, mms, mme, rstc;
  } scen_t;

  scen_t sc [NS];

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
  endtask

  function automatic scen_t blank(input string nm);
    scen_t s;
    s.name = nm;
    for (int j = 0; j < 3; j++) begin
      s.cap[j] = -1; s.cv[j] = '0; s.cb[j] = '0;
      s.bs[j] = -1; s.bl[j] = NN; s.bb[j] = '0;
    end
    s.ovs = 1000; s.ove = 1000; s.mms = 1000; s.mme = 1000; s.rstc = -1;
    return s;
  endfunction

  task automatic run(input scen_t s);
    logic          exv, ebz, eov, emm;
    logic [DW-1:0] exo;
    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      if (c >= 2) begin
        exv = 1'b0; exo = '0;
        for (int j = 0; j < 3; j++)
          if (s.bs[j] >= 0 && c >= s.bs[j] && c < s.bs[j] + s.bl[j]) begin
            exv = 1'b1;
            exo = s.bb[j] + DW'(c - s.bs[j]);
          end
        ebz = exv;
        eov = (c >= s.ovs && c < s.ove);
        emm = (c >= s.mms && c < s.mme);
        chk({s.name, ".x_valid"}, c, 32'(x_valid), 32'(exv));
        chk({s.name, ".x_out"}, c, 32'(x_out), 32'(exo));
        chk({s.name, ".busy"}, c, 32'(busy), 32'(ebz));
        chk({s.name, ".overrun"}, c, 32'(overrun), 32'(eov));
        chk({s.name, ".mismatch"}, c, 32'(valid_mismatch), 32'(emm));
      end
      rst = (c < 2) || (c == s.rstc);
      in_valid = '0;
      for (int i = 0; i < NN; i++) in_data[i*DW +: DW] = 16'hBE00 + DW'(i);
      for (int j = 0; j < 3; j++)
        if (s.cap[j] == c) begin
          in_valid = s.cv[j];
          for (int i = 0; i < NN; i++) in_data[i*DW +: DW] = s.cb[j] + DW'(i);
        end
    end
  endtask

  initial begin
    logic [NN-1:0] full;
    full = '1;

    sc[0] = blank("single");
    sc[0].cap = '{5, -1, -1}; sc[0].cv = '{full, 0, 0};
    sc[0].cb = '{16'h0100, 0, 0};
    sc[0].bs = '{6, -1, -1}; sc[0].bb = '{16'h0100, 0, 0};

    sc[1] = blank("pending");
    sc[1].cap = '{5, 8, -1}; sc[1].cv = '{full, full, 0};
    sc[1].cb = '{16'h0100, 16'h0200, 0};
    sc[1].bs = '{6, 16, -1}; sc[1].bb = '{16'h0100, 16'h0200, 0};

    sc[2] = blank("overrun");
    sc[2].cap = '{5, 8, 10}; sc[2].cv = '{full, full, full};
    sc[2].cb = '{16'h0100, 16'h0200, 16'h0300};
    sc[2].bs = '{6, 16, -1}; sc[2].bb = '{16'h0100, 16'h0200, 0};
    sc[2].ovs = 11;

    sc[3] = blank("lastword");
    sc[3].cap = '{5, 15, -1}; sc[3].cv = '{full, full, 0};
    sc[3].cb = '{16'h0100, 16'h0200, 0};
    sc[3].bs = '{6, 16, -1}; sc[3].bb = '{16'h0100, 16'h0200, 0};

    sc[4] = blank("partial");
    sc[4].cap = '{5, 8, -1}; sc[4].cv = '{10'b0000001111, full, 0};
    sc[4].cb = '{16'h0500, 16'h0100, 0};
    sc[4].bs = '{9, -1, -1}; sc[4].bb = '{16'h0100, 0, 0};
    sc[4].mms = 6;

    sc[5] = blank("reset");
    sc[5].cap = '{5, 8, 14}; sc[5].cv = '{full, full, full};
    sc[5].cb = '{16'h0100, 16'h0200, 16'h0600};
    sc[5].bs = '{6, 15, -1}; sc[5].bl = '{5, NN, NN};
    sc[5].bb = '{16'h0100, 16'h0600, 0};
    sc[5].rstc = 10;

    sc[6] = blank("refill");
    sc[6].cap = '{5, 8, 15}; sc[6].cv = '{full, full, full};
    sc[6].cb = '{16'h0100, 16'h0200, 16'h0300};
    sc[6].bs = '{6, 16, 26}; sc[6].bb = '{16'h0100, 16'h0200, 16'h0300};

    for (int k = 0; k < NS; k++) run(sc[k]);

    // Partial strobe mid-burst, then reset clears the sticky flag.
    sc[0] = blank("mmreset");
    sc[0].cap = '{5, 7, -1}; sc[0].cv = '{full, 10'b0000000001, 0};
    sc[0].cb = '{16'h0100, 16'h0700, 0};
    sc[0].bs = '{6, -1, -1}; sc[0].bl = '{7, NN, NN};
    sc[0].bb = '{16'h0100, 0, 0};
    sc[0].mms = 8; sc[0].mme = 13; sc[0].rstc = 12;
    run(sc[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
